mxv_sequencer: RTL and testbench

MXV_SEQUENCER -- requirements
Module: mxv_sequencer

---
 rtl/mxv_pkg.sv | 27 ++
 rtl/mxv_wave_mask.sv | 28 ++
 rtl/mxv_sequencer.sv | 137 +++++++++++++
 tb/tb_mxv_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mxv_pkg.sv
// mxv_pkg: shared types and sizing for the matrix-vector sequencer.
//   NUM_PE      default number of processing elements
//   CNT_W       width of pop/drain/output counters and the latched N (holds 0..NUM_PE)
//   IDX_W       width of the result row index
//   state_t     sequencer FSM states
//   mask_mode_t selects ramp (feed) or drain shape in the wavefront mask
package mxv_pkg;

  localparam int NUM_PE = 4;
  localparam int CNT_W  = 4;
  localparam int IDX_W  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_OUTPUT,
    S_DONE
  } state_t;

  typedef enum logic {
    MASK_RAMP,
    MASK_DRAIN
  } mask_mode_t;

endpackage

// File: rtl/mxv_wave_mask.sv
// mxv_wave_mask: purely combinational wavefront mask for the PE array.
//   mode  MASK_RAMP : bits 0..pos-1 set (pos = pop number j)
//         MASK_DRAIN: bits pos..n-1 set (pos = drain cycle d)
//   pos   wavefront position
//   n     active matrix dimension; bits >= n are always 0
//   mask  per-PE enable pattern
module mxv_wave_mask
  import mxv_pkg::*;
#(
  parameter int NUM_PE = mxv_pkg::NUM_PE
) (
  input  mask_mode_t         mode,
  input  logic [CNT_W-1:0]   pos,
  input  logic [CNT_W-1:0]   n,
  output logic [NUM_PE-1:0]  mask
);

  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (CNT_W'(i) < n) begin
        if (mode == MASK_RAMP) mask[i] = (CNT_W'(i) < pos);
        else                   mask[i] = (CNT_W'(i) >= pos);
      end
    end
  end

endmodule

// File: rtl/mxv_sequencer.sv
// mxv_sequencer: sequences one matrix-vector pass over a systolic row of PEs.
//   clk, rst        clock; asynchronous active-low reset
//   start, mat_size pass request and dimension N (latched when start is accepted)
//   fifo_empty      show-ahead operand FIFO status
//   fifo_rd         pop one operand column (same-cycle data)
//   pe_en           per-PE accumulate enable (wavefront ramp, then drain)
//   acc_clr         clear all accumulators
//   res_valid       result row res_idx presented to writeback
//   busy, done, err pass in progress / end-of-pass pulse / illegal mat_size
//
// state  | meaning
// IDLE   | waiting for start
// CLEAR  | one cycle of accumulator clear
// FEED   | pop N operand columns, ramping the wavefront; stalls on empty FIFO
// DRAIN  | N-1 cycles letting the wavefront leave the array
// OUTPUT | N cycles presenting result rows 0..N-1
// DONE   | one-cycle done pulse (with err if mat_size was illegal)
module mxv_sequencer
  import mxv_pkg::*;
#(
  parameter int NUM_PE = mxv_pkg::NUM_PE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        mat_size,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  output logic [NUM_PE-1:0] pe_en,
  output logic              acc_clr,
  output logic              res_valid,
  output logic [IDX_W-1:0]  res_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t             state;
  logic [CNT_W-1:0]   n_q;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               err_q;
  logic               mat_ok;
  logic               pop;
  mask_mode_t         mask_mode;
  logic [NUM_PE-1:0]  mask;

  assign cnt_nxt = cnt + CNT_W'(1);
  assign mat_ok  = (mat_size != 4'd0) && (mat_size <= 4'(NUM_PE));

  // A show-ahead FIFO must never be popped while empty, so the pop (and the
  // matching PE enable) is qualified by fifo_empty in the same cycle; every
  // other output decodes from registered state only.
  assign pop = (state == S_FEED) && !fifo_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      n_q   <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt <= '0;
            if (mat_ok) begin
              n_q   <= CNT_W'(mat_size);
              err_q <= 1'b0;
              state <= S_CLEAR;
            end else begin
              err_q <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_CLEAR: begin
          cnt   <= '0;
          state <= S_FEED;
        end
        S_FEED: begin
          if (pop) begin
            if (cnt_nxt == n_q) begin
              cnt   <= '0;
              state <= (n_q == CNT_W'(1)) ? S_OUTPUT : S_DRAIN;
            end else begin
              cnt <= cnt_nxt;
            end
          end
        end
        S_DRAIN: begin
          if (cnt_nxt == n_q - CNT_W'(1)) begin
            cnt   <= '0;
            state <= S_OUTPUT;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        S_OUTPUT: begin
          if (cnt_nxt == n_q) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        S_DONE: begin
          err_q <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // cnt+1 is the pop number j in FEED and the drain cycle d in DRAIN.
  assign mask_mode = (state == S_DRAIN) ? MASK_DRAIN : MASK_RAMP;

  mxv_wave_mask #(
    .NUM_PE (NUM_PE)
  ) u_wave_mask (
    .mode (mask_mode),
    .pos  (cnt_nxt),
    .n    (n_q),
    .mask (mask)
  );

  assign fifo_rd   = pop;
  assign pe_en     = (pop || (state == S_DRAIN)) ? mask : '0;
  assign acc_clr   = (state == S_CLEAR);
  assign res_valid = (state == S_OUTPUT);
  assign res_idx   = res_valid ? cnt[IDX_W-1:0] : '0;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign err       = done && err_q;

endmodule

// File: tb/tb_mxv_sequencer.sv
// tb_mxv_sequencer: directed bench for mxv_sequencer with a cycle-level
// expectation model built from the pass rules (clear, feed with stalls,
// drain, output, done) and literal pins on latency, pop count and pe_en order.
module tb_mxv_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] mat_size;
  logic       fifo_empty;
  logic       fifo_rd;
  logic [3:0] pe_en;
  logic       acc_clr;
  logic       res_valid;
  logic [1:0] res_idx;
  logic       busy;
  logic       done;
  logic       err;

  mxv_sequencer #(.NUM_PE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mat_size   (mat_size),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .pe_en      (pe_en),
    .acc_clr    (acc_clr),
    .res_valid  (res_valid),
    .res_idx    (res_idx),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       fifo_rd;
    logic [3:0] pe_en;
    logic       acc_clr;
    logic       res_valid;
    logic [1:0] res_idx;
    logic       busy;
    logic       done;
    logic       err;
  } obs_t;

  obs_t       exp_q[$];
  obs_t       cmp_e;
  obs_t       cmp_a;
  logic [3:0] pe_seq[$];
  int         errors = 0;
  int         checks = 0;
  bit         chk_on = 1'b0;
  int         done_k;
  int         rd_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected outputs for every cycle from the one where start is driven,
  // derived from the pass description: 1 clear cycle, pops that skip
  // stalled cycles, N-1 drain cycles, N output rows, 1 done cycle.
  task automatic build_model(input int n, input logic [63:0] stall);
    obs_t o;
    int   j;
    int   k;
    exp_q.push_back('0);
    if (n >= 1 && n <= 4) begin
      o = '0; o.busy = 1'b1; o.acc_clr = 1'b1;
      exp_q.push_back(o);
      j = 0;
      k = 1;
      while (j < n && k < 64) begin
        o = '0; o.busy = 1'b1;
        if (!stall[k]) begin
          j++;
          o.fifo_rd = 1'b1;
          o.pe_en   = 4'((1 << j) - 1);
        end
        exp_q.push_back(o);
        k++;
      end
      for (int d = 1; d < n; d++) begin
        o = '0; o.busy = 1'b1;
        o.pe_en = 4'(((1 << n) - 1) & ~((1 << d) - 1));
        exp_q.push_back(o);
      end
      for (int i = 0; i < n; i++) begin
        o = '0; o.busy = 1'b1; o.res_valid = 1'b1; o.res_idx = 2'(i);
        exp_q.push_back(o);
      end
    end
    o = '0; o.busy = 1'b1; o.done = 1'b1; o.err = !(n >= 1 && n <= 4);
    exp_q.push_back(o);
  endtask

  // Single compare process: one whole-output check per cycle at negedge.
  always @(negedge clk) begin
    if (chk_on) begin
      cmp_e = (exp_q.size() > 0) ? exp_q.pop_front() : obs_t'('0);
      cmp_a = {fifo_rd, pe_en, acc_clr, res_valid, res_idx, busy, done, err};
      checks++;
      if (cmp_a !== cmp_e) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t actual=%b required=%b (rd,pe_en,clr,rv,idx,busy,done,err)",
                 $time, cmp_a, cmp_e);
      end
    end
  end

  function automatic logic [31:0] pack_seq();
    logic [31:0] v;
    v = '0;
    foreach (pe_seq[i]) v = (v << 4) | 32'(pe_seq[i]);
    return v;
  endfunction

  // One pass; cycle k is the interval after the k-th edge from the edge
  // that samples start (k=0). done seen at cycle k is sampled at edge k+1.
  task automatic run_pass(input string tag, input int n, input logic [63:0] stall,
                          input bit junk, input int rst_at);
    @(posedge clk); #1;
    build_model(n, stall);
    start      = 1'b1;
    mat_size   = 4'(n);
    fifo_empty = 1'b0;
    done_k     = -1;
    rd_cnt     = 0;
    pe_seq.delete();
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done && done_k < 0) done_k = k;
      start      = junk && (k == 2 || k == 6);
      mat_size   = (junk && k >= 2) ? 4'd2 : 4'(n);
      fifo_empty = (k < 64) ? stall[k] : 1'b0;
      if (rst_at >= 0 && k == rst_at) begin
        exp_q.delete();
        rst = 1'b0;
        #1;
        check({tag, "_rst_immediate"},
              {24'd0, fifo_rd, pe_en, acc_clr, res_valid, busy, done}, 32'd0);
      end
      if (rst_at >= 0 && k == rst_at + 2) rst = 1'b1;
      #1;
      if (pe_en != 4'd0) pe_seq.push_back(pe_en);
      if (fifo_rd) rd_cnt++;
    end
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    mat_size   = 4'd0;
    fifo_empty = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_on = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;

    run_pass("n4", 4, 64'h0, 1'b0, -1);
    check("n4_done_edge", 32'(done_k + 1), 32'd13);
    check("n4_pops", 32'(rd_cnt), 32'd4);
    check("n4_pe_seq", pack_seq(), 32'h0137FEC8);

    run_pass("n4_stall", 4, 64'h18, 1'b0, -1);
    check("stall_done_edge", 32'(done_k + 1), 32'd15);
    check("stall_pops", 32'(rd_cnt), 32'd4);
    check("stall_pe_seq", pack_seq(), 32'h0137FEC8);

    run_pass("n1", 1, 64'h0, 1'b0, -1);
    check("n1_done_edge", 32'(done_k + 1), 32'd4);
    check("n1_pe_seq", pack_seq(), 32'h1);
    check("n1_pe_len", 32'(pe_seq.size()), 32'd1);

    run_pass("n0", 0, 64'h0, 1'b0, -1);
    check("n0_done_edge", 32'(done_k + 1), 32'd1);
    check("n0_pops", 32'(rd_cnt), 32'd0);
    check("n0_pe_len", 32'(pe_seq.size()), 32'd0);

    run_pass("n5", 5, 64'h0, 1'b0, -1);
    check("n5_done_edge", 32'(done_k + 1), 32'd1);
    check("n5_pops", 32'(rd_cnt), 32'd0);
    check("n5_pe_len", 32'(pe_seq.size()), 32'd0);

    run_pass("n3", 3, 64'h4, 1'b0, -1);
    check("n3_done_edge", 32'(done_k + 1), 32'd11);
    check("n3_pe_seq", pack_seq(), 32'h00013764);

    run_pass("rst_drain", 4, 64'h0, 1'b0, 6);
    check("rst_no_done", 32'(done_k), 32'hFFFFFFFF);

    run_pass("after_rst", 4, 64'h0, 1'b0, -1);
    check("after_rst_done_edge", 32'(done_k + 1), 32'd13);
    check("after_rst_pe_seq", pack_seq(), 32'h0137FEC8);

    run_pass("junk", 4, 64'h0, 1'b1, -1);
    check("junk_done_edge", 32'(done_k + 1), 32'd13);
    check("junk_pops", 32'(rd_cnt), 32'd4);
    check("junk_pe_seq", pack_seq(), 32'h0137FEC8);

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
